// File: rtl/mod_counter_chain_pkg.sv
// Shared constants for the modulo counter chain: default digit width and the
// terminal-value vectors for the MM:SS and HH:MM display bases.
package mod_counter_chain_pkg;

  localparam int CONT_W    = 4;
  localparam int CONT_NDIG = 4;

  // Digit 0 is the least significant field (rightmost nibble).
  localparam logic [4*CONT_W-1:0] MAXV_MMSS = {4'd5, 4'd9, 4'd5, 4'd9};
  localparam logic [4*CONT_W-1:0] MAXV_HHMM = {4'd2, 4'd9, 4'd5, 4'd9};

  typedef struct packed {
    logic en;
    logic up;
    logic load;
  } cnt_ctl_t;

endpackage

// File: rtl/mod_counter_chain_if.sv
// Control/load/count bundle between the tick source, the counter chain and
// the display decode.
interface mod_counter_chain_if #(
  parameter int NDIG = 4,
  parameter int W    = 4
);
  logic              En;
  logic              Up;
  logic              Load;
  logic [NDIG*W-1:0] LoadVal;
  logic [NDIG*W-1:0] Q;
  logic              Carry;

  modport master (output En, Up, Load, LoadVal, input  Q, Carry);
  modport slave  (input  En, Up, Load, LoadVal, output Q, Carry);
endinterface

// File: rtl/mod_counter_stage.sv
// One modulo digit: wraps at MAXV_I going up, reloads MAXV_I going down,
// and clamps out-of-range load values to zero.
module mod_counter_stage #(
  parameter int           W      = 4,
  parameter logic [W-1:0] MAXV_I = 4'd9
) (
  input  logic         CLK,
  input  logic         CLR,
  input  logic         Load,
  input  logic [W-1:0] LoadVal,
  input  logic         Step,
  input  logic         Up,
  output logic [W-1:0] Q,
  output logic         AtMax,
  output logic         AtZero
);

  logic [W-1:0] q;

  assign AtMax  = (q == MAXV_I);
  assign AtZero = (q == '0);
  assign Q      = q;

  always_ff @(posedge CLK) begin
    if (CLR)
      q <= '0;
    else if (Load)
      q <= (LoadVal > MAXV_I) ? '0 : LoadVal;
    else if (Step) begin
      if (Up) q <= AtMax  ? '0     : q + 1'b1;
      else    q <= AtZero ? MAXV_I : q - 1'b1;
    end
  end

endmodule

// File: rtl/mod_counter_chain.sv
// NDIG-digit cascade of modulo counters with shared enable, up/down, parallel
// load and a registered pulse when the whole chain wraps.
module mod_counter_chain
  import mod_counter_chain_pkg::*;
#(
  parameter int                NDIG = CONT_NDIG,
  parameter int                W    = CONT_W,
  parameter logic [NDIG*W-1:0] MAXV = MAXV_MMSS
) (
  input  logic                 CLK,
  input  logic                 CLR,
  mod_counter_chain_if.slave   bus
);

  cnt_ctl_t                   ctl;
  logic [NDIG-1:0]            at_max, at_zero, step;
  logic [NDIG:0]              up_chain, dn_chain;
  logic [NDIG-1:0][W-1:0]     q;
  logic                       carry;

  assign ctl = '{en: bus.En, up: bus.Up, load: bus.Load};

  // Ripple enables: bit i is set when every lower digit sits on its boundary.
  assign up_chain[0] = 1'b1;
  assign dn_chain[0] = 1'b1;

  genvar i;
  generate
    for (i = 0; i < NDIG; i++) begin : g_dig
      assign up_chain[i+1] = up_chain[i] & at_max[i];
      assign dn_chain[i+1] = dn_chain[i] & at_zero[i];
      assign step[i]       = ctl.en & ~ctl.load & (ctl.up ? up_chain[i] : dn_chain[i]);

      mod_counter_stage #(
        .W      (W),
        .MAXV_I (MAXV[i*W +: W])
      ) u_stage (
        .CLK     (CLK),
        .CLR     (CLR),
        .Load    (ctl.load),
        .LoadVal (bus.LoadVal[i*W +: W]),
        .Step    (step[i]),
        .Up      (ctl.up),
        .Q       (q[i]),
        .AtMax   (at_max[i]),
        .AtZero  (at_zero[i])
      );
    end
  endgenerate

  // Every digit on its boundary for the current direction means this step wraps all.
  always_ff @(posedge CLK) begin
    if (CLR) carry <= 1'b0;
    else     carry <= ctl.en & ~ctl.load & (ctl.up ? up_chain[NDIG] : dn_chain[NDIG]);
  end

  assign bus.Q     = q;
  assign bus.Carry = carry;

endmodule

// File: tb/tb_mod_counter_chain.sv
// Scoreboard bench: MM:SS chain under directed and random stimulus, plus a
// 1-digit mod-6 chain counting continuously, both checked against a
// mixed-radix integer model.
module tb_mod_counter_chain;
  import mod_counter_chain_pkg::*;

  logic CLK = 1'b0;
  logic CLR;
  always #5 CLK = ~CLK;

  mod_counter_chain_if #(.NDIG(4), .W(4)) busa ();
  mod_counter_chain_if #(.NDIG(1), .W(3)) busb ();

  mod_counter_chain #(.NDIG(4), .W(4), .MAXV(MAXV_MMSS)) dut_a (
    .CLK (CLK), .CLR (CLR), .bus (busa)
  );
  mod_counter_chain #(.NDIG(1), .W(3), .MAXV(3'd5)) dut_b (
    .CLK (CLK), .CLR (CLR), .bus (busb)
  );

  typedef struct { logic [15:0] q; logic c; } exp_a_t;
  typedef struct { logic [2:0]  q; logic c; } exp_b_t;
  exp_a_t qa[$];
  exp_b_t qb[$];

  int checks = 0;
  int errors = 0;
  int ma = 0, mb = 0;
  bit ca = 0, cb = 0;
  int rad[4];
  int total_a = 1;
  logic [15:0] mx;

  // Mixed-radix view of the MM:SS chain: count is an integer in [0, total_a).
  function automatic int load_val(input logic [15:0] lv);
    int v = 0;
    for (int i = 3; i >= 0; i--) begin
      int d;
      d = int'(lv[i*4 +: 4]);
      if (d >= rad[i]) d = 0;
      v = v * rad[i] + d;
    end
    return v;
  endfunction

  function automatic logic [15:0] to_q(input int v);
    logic [15:0] r = '0;
    int t = v;
    for (int i = 0; i < 4; i++) begin
      r[i*4 +: 4] = 4'(t % rad[i]);
      t = t / rad[i];
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input bit clr, input bit en, input bit up, input bit ld, input logic [15:0] lv);
    @(negedge CLK);
    CLR = clr; busa.En = en; busa.Up = up; busa.Load = ld; busa.LoadVal = lv;
    @(posedge CLK);
    if (clr)     begin ma = 0; ca = 0; end
    else if (ld) begin ma = load_val(lv); ca = 0; end
    else if (en) begin
      if (up) begin ca = (ma == total_a - 1); ma = (ma + 1) % total_a; end
      else    begin ca = (ma == 0); ma = (ma + total_a - 1) % total_a; end
    end
    else ca = 0;
    qa.push_back('{to_q(ma), ca});
    if (clr) begin mb = 0; cb = 0; end
    else     begin cb = (mb == 5); mb = (mb + 1) % 6; end
    qb.push_back('{3'(mb), cb});
  endtask

  // Monitor: outputs are registered, so the negedge after each push is stable.
  always @(negedge CLK) begin
    if (qa.size() > 0) begin
      exp_a_t e;
      e = qa.pop_front();
      chk("a_q", busa.Q, e.q);
      chk("a_carry", {15'd0, busa.Carry}, {15'd0, e.c});
    end
    if (qb.size() > 0) begin
      exp_b_t e;
      e = qb.pop_front();
      chk("b_q", {13'd0, busb.Q}, {13'd0, e.q});
      chk("b_carry", {15'd0, busb.Carry}, {15'd0, e.c});
      chk("b_range", {15'd0, (busb.Q > 3'd5)}, 16'd0);
    end
  end

  initial begin
    mx = MAXV_MMSS;
    for (int i = 0; i < 4; i++) begin
      rad[i]  = int'(mx[i*4 +: 4]) + 1;
      total_a = total_a * rad[i];
    end
    CLR = 1'b1;
    busa.En = 1'b1; busa.Up = 1'b1; busa.Load = 1'b0; busa.LoadVal = '0;
    busb.En = 1'b1; busb.Up = 1'b1; busb.Load = 1'b0; busb.LoadVal = '0;

    // Reset held with En high: no counting.
    cyc(1, 1, 1, 0, 16'h0);
    cyc(1, 1, 1, 0, 16'h0);
    // Up wrap from 5958.
    cyc(0, 1, 1, 1, 16'h5958);
    repeat (3) cyc(0, 1, 1, 0, 16'h0);
    // Down borrow from 0100, then 0000 -> 5959.
    cyc(0, 0, 0, 1, 16'h0100);
    repeat (2) cyc(0, 1, 0, 0, 16'h0);
    cyc(0, 0, 0, 1, 16'h0000);
    cyc(0, 1, 0, 0, 16'h0);
    cyc(0, 1, 0, 0, 16'h0);
    // Load clamp beats En.
    cyc(0, 1, 1, 1, 16'h7A34);
    // Direction flip.
    cyc(0, 0, 1, 1, 16'h0009);
    cyc(0, 1, 1, 0, 16'h0);
    cyc(0, 1, 0, 0, 16'h0);
    cyc(0, 1, 0, 0, 16'h0);
    // Hold, then CLR during Load.
    repeat (2) cyc(0, 0, 1, 0, 16'h0);
    cyc(0, 0, 1, 1, 16'h5959);
    cyc(1, 1, 1, 1, 16'h1234);

    begin
      bit up = 1;
      for (int n = 0; n < 600; n++) begin
        logic [15:0] lv;
        bit clr, ld, en;
        case ($urandom_range(3))
          0:       lv = 16'h5959;
          1:       lv = 16'h0000;
          2:       lv = 16'h5958;
          default: lv = 16'($urandom);
        endcase
        clr = ($urandom_range(79) == 0);
        ld  = ($urandom_range(11) == 0);
        en  = ($urandom_range(4) != 0);
        if ($urandom_range(9) == 0) up = ~up;
        cyc(clr, en, up, ld, lv);
      end
    end

    repeat (2) @(negedge CLK);
    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d pending expected 0/0", qa.size(), qb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mod_counter_chain.md
# mod_counter_chain

Parametrised cascade of NDIG modulo counter digits with shared enable, up/down direction, parallel load and a chain-wrap carry pulse. It generalises the fixed mod-6 counter into a configurable multi-digit time/count base, e.g. MM:SS for the display path. It sits between the tick generator, which drives the enable, and the 7-segment decode/display logic, which reads Q.

## Interface
- NDIG, 4, number of cascaded digits (1..8)
- W, 4, bits per digit
- MAXV, {4'd5,4'd9,4'd5,4'd9}, packed NDIG*W vector; digit i terminal value (modulus-1) at MAXV[i*W +: W]; digit 0 is least significant; each field ≥1
- CLK  input  1  clock, rising edge
- CLR  input  1  reset; synchronous, active-high
- En  input  1  count enable; one step per cycle while high
- Up  input  1  direction: 1 = up, 0 = down
- Load  input  1  parallel load strobe
- LoadVal  input  NDIG*W  value to load, same packing as MAXV
- Q  output  NDIG*W  current count, same packing
- Carry  output  1  registered one-cycle pulse when the whole chain wraps

## Operation
- Priority per edge: CLR > Load > En > hold.
- CLR: every digit = 0, Carry = 0.
- Load: digit i = LoadVal field i if ≤ MAXV field i, else 0; Carry = 0; no count this cycle even if En = 1.
- Step condition, up: digit i steps iff En and all digits j<i equal MAXV_j. Digit 0 steps on En alone.
- Step condition, down: digit i steps iff En and all digits j<i equal 0.
- Up step: MAXV_i → 0, otherwise +1. Down step: 0 → MAXV_i, otherwise −1.
- Carry = 1 in the cycle after an En step in which every digit wrapped: all-max → all-zero when up, all-zero → all-max when down. Otherwise Carry = 0.
- En = 0: Q holds and Carry = 0.
- Arithmetic is per digit in W bits. A digit never holds a value > MAXV_i, so no intermediate overflow occurs.

## Timing
- Reset values: Q = 0 (all digits), Carry = 0.
- Latency: inputs sampled on edge k; Q and Carry reflect them after edge k. There is no combinational path from any input to any output.
- Up is sampled every cycle. A direction change mid-count takes effect on the same edge it is sampled; there is no flush.
- Back-to-back En: one step per cycle, with no dead cycle after a wrap.
- Load and En in the same cycle: Load wins and Carry = 0. Counting resumes from the loaded value on the next En edge.
- CLR mid-count or during Load: the next edge gives Q = 0 and Carry = 0, and any pending wrap is discarded.
- Carry is exactly one cycle wide, even with continuous En on a 1-digit chain where MAXV = 1, because it is recomputed every edge.

## Structure
- Shared package/include cont_defs: default digit width, default MAXV for MM:SS, and a MAXV_HHMM constant {4'd2,4'd9,4'd5,4'd9} for the hours display.
- Sub-module mod_counter_stage, parameters W and MAXV_I:
  - inputs CLK, CLR, Load, LoadVal[W-1:0], Step, Up
  - outputs Q[W-1:0], AtMax, AtZero
- The top generates NDIG stages and builds the ripple step enables from AtMax/AtZero (combinational AND chain).
- The top registers Carry from (En & no Load & all stages at the wrap boundary for the current Up).

## Test plan
- Reset: CLR=1 for 2 cycles with En=1 → Q=16'h0000 and Carry=0 after the first edge; no counting while CLR=1.
- Up wrap, default MAXV: Load 16'h5958, then En=1, Up=1 for 3 cycles → Q = 5959, 0000, 0001; Carry=1 only in the cycle showing 0000.
- Down borrow: Load 16'h0100, Up=0, En=1 for 2 cycles → Q = 0059, 0058; Carry=0 throughout. From 0000, one down step → 5959 with Carry=1.
- Load clamp and priority: Load=1, En=1, LoadVal=16'h7A34 → Q=16'h0034 (digits 3 and 2 out of range become 0); no step that cycle.
- Direction flip mid-run: from 0009, Up=1 step → 0010; then Up=0 step → 0009; then Up=0 step → 0008.
- Parameter sweep: NDIG=1, W=3, MAXV=5 with continuous En and Up=1 → Q cycles 0..5. Carry pulses every 6th cycle, is one cycle wide, and Q never reaches 6 or 7.
